// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU sequencer: FSM states, decoded instruction kinds and
// the datapath control word that the datapath imports as well.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH1,
    DECODE,
    FETCH2,
    MEM_RD,
    LD_WB,
    ST,
    JMP,
    ALU_EX,
    ALU_WB,
    MOV
  } state_t;

  typedef enum logic [2:0] {
    K_LDA,
    K_STA,
    K_JMP,
    K_ALUI,
    K_ALU,
    K_MOV
  } kind_t;

  localparam logic [2:0] CLASS_LDA = 3'b000;
  localparam logic [2:0] CLASS_STA = 3'b001;
  localparam logic [2:0] CLASS_JMP = 3'b010;
  localparam logic [3:0] OP_MOV    = 4'b0110;
  localparam logic [3:0] OP_ALUI   = 4'b0111;

  typedef struct packed {
    logic sel_mem_src_pc;
    logic sel_mem_src_tr;
    logic ld_ir;
    logic ld_di;
    logic ld_pc;
    logic ld_tr;
    logic ld_alu;
    logic ld_czn;
    logic sel_czn_src_alu;
    logic sel_alu_src_tr;
    logic sel_alu_src_reg1;
    logic sel_ir_4_3;
    logic sel_ir_3_2;
    logic sel_rf_write_src_tr_12_5;
    logic sel_rf_write_src_alu;
    logic sel_rf_write_src_reg1;
    logic write_reg_en;
    logic mem_write;
    logic jump_phase;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Every 4-bit upper nibble maps to a kind: 1xxx is ALU reg-reg, 0110/0111
  // are MOV/ALUI, and the remaining 00xx/010x fall to the class field.
  function automatic kind_t decode_kind(input logic [3:0] op);
    kind_t k;
    if (op[3])              k = K_ALU;
    else if (op == OP_MOV)  k = K_MOV;
    else if (op == OP_ALUI) k = K_ALUI;
    else begin
      case (op[3:1])
        CLASS_LDA: k = K_LDA;
        CLASS_STA: k = K_STA;
        CLASS_JMP: k = K_JMP;
        default:   k = K_JMP;
      endcase
    end
    return k;
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH1) || (s == FETCH2) || (s == MEM_RD) || (s == ST);
  endfunction

endpackage

// File: rtl/instr_counter.sv
// Retired-instruction counter, wrapping at all-ones. Only compiled and
// instantiated when CTRL_PERF_CNT_EN is defined.
`ifdef CTRL_PERF_CNT_EN
module instr_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/control_unit.sv
// Moore sequencer for the 8-bit CPU: fetch/decode/execute FSM driving the
// datapath control word. Optional retired counter under CTRL_PERF_CNT_EN.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ir,
  input  logic             mem_wait,
  output ctrl_t            ctrl_o,
  output state_t           state_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] retired_o
);

  state_t state_q, state_d;
  kind_t  kind_q, kind_d;
  ctrl_t  ctrl_raw;
  logic   done_raw;
  logic   wait_hold;

  // dst/src fields steer the datapath directly; the sequencer never uses them.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[3:0];

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    case (state_q)
      FETCH1: if (!mem_wait) state_d = DECODE;
      DECODE: begin
        kind_d = decode_kind(ir[7:4]);
        case (kind_d)
          K_MOV:   state_d = MOV;
          K_ALU:   state_d = ALU_EX;
          default: state_d = FETCH2;
        endcase
      end
      FETCH2: begin
        if (!mem_wait) begin
          case (kind_q)
            K_LDA:   state_d = MEM_RD;
            K_STA:   state_d = ST;
            K_JMP:   state_d = JMP;
            default: state_d = ALU_EX;
          endcase
        end
      end
      MEM_RD:  if (!mem_wait) state_d = LD_WB;
      ST:      if (!mem_wait) state_d = FETCH1;
      ALU_EX:  state_d = ALU_WB;
      default: state_d = FETCH1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH1;
      kind_q  <= K_MOV;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  // A stalled memory state keeps its address select but drops every strobe
  // that would commit something.
  assign wait_hold = mem_wait && is_mem_state(state_q);

  always_comb begin
    ctrl_raw = CTRL_IDLE;
    done_raw = 1'b0;
    case (state_q)
      FETCH1: begin
        ctrl_raw.sel_mem_src_pc = 1'b1;
        ctrl_raw.ld_ir          = !wait_hold;
        ctrl_raw.ld_di          = !wait_hold;
        ctrl_raw.ld_pc          = !wait_hold;
      end
      FETCH2: begin
        ctrl_raw.sel_mem_src_pc = 1'b1;
        ctrl_raw.ld_tr          = !wait_hold;
        ctrl_raw.ld_pc          = !wait_hold;
      end
      MEM_RD: begin
        ctrl_raw.sel_mem_src_tr = 1'b1;
        ctrl_raw.ld_tr          = !wait_hold;
      end
      LD_WB: begin
        ctrl_raw.sel_rf_write_src_tr_12_5 = 1'b1;
        ctrl_raw.sel_ir_4_3               = 1'b1;
        ctrl_raw.write_reg_en             = 1'b1;
        done_raw                          = 1'b1;
      end
      ST: begin
        ctrl_raw.sel_mem_src_tr = 1'b1;
        ctrl_raw.sel_ir_4_3     = 1'b1;
        ctrl_raw.mem_write      = !wait_hold;
        done_raw                = !wait_hold;
      end
      JMP: begin
        ctrl_raw.jump_phase = 1'b1;
        ctrl_raw.ld_pc      = 1'b1;
        done_raw            = 1'b1;
      end
      ALU_EX: begin
        ctrl_raw.ld_alu           = 1'b1;
        ctrl_raw.ld_czn           = 1'b1;
        ctrl_raw.sel_czn_src_alu  = 1'b1;
        ctrl_raw.sel_ir_3_2       = 1'b1;
        ctrl_raw.sel_alu_src_tr   = (kind_q == K_ALUI);
        ctrl_raw.sel_alu_src_reg1 = (kind_q != K_ALUI);
      end
      ALU_WB: begin
        ctrl_raw.sel_rf_write_src_alu = 1'b1;
        ctrl_raw.sel_ir_3_2           = 1'b1;
        ctrl_raw.write_reg_en         = 1'b1;
        done_raw                      = 1'b1;
      end
      MOV: begin
        ctrl_raw.sel_rf_write_src_reg1 = 1'b1;
        ctrl_raw.sel_ir_3_2            = 1'b1;
        ctrl_raw.write_reg_en          = 1'b1;
        done_raw                       = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset blanks the strobes combinationally, not just at the next edge.
  assign ctrl_o       = rst ? ctrl_raw : CTRL_IDLE;
  assign instr_done_o = rst & done_raw;
  assign state_o      = state_q;

`ifdef CTRL_PERF_CNT_EN
  instr_counter #(
    .CNT_W (CNT_W)
  ) u_instr_counter (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (instr_done_o),
    .count_o (retired_o)
  );
`else
  assign retired_o = '0;
`endif

  a_mem_src_excl: assert property (@(posedge clk) disable iff (!rst)
    !(ctrl_o.sel_mem_src_pc && ctrl_o.sel_mem_src_tr));
  a_alu_src_excl: assert property (@(posedge clk) disable iff (!rst)
    !(ctrl_o.sel_alu_src_tr && ctrl_o.sel_alu_src_reg1));
  a_ir_sel_excl: assert property (@(posedge clk) disable iff (!rst)
    !(ctrl_o.sel_ir_4_3 && ctrl_o.sel_ir_3_2));
  a_rf_src_excl: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({ctrl_o.sel_rf_write_src_tr_12_5, ctrl_o.sel_rf_write_src_alu,
              ctrl_o.sel_rf_write_src_reg1}));
  a_pc_vs_rf: assert property (@(posedge clk) disable iff (!rst)
    !(ctrl_o.ld_pc && ctrl_o.write_reg_en));
  a_jump_phase: assert property (@(posedge clk) disable iff (!rst)
    ctrl_o.jump_phase |-> (state_o == JMP));

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction vector table, wait-state,
// reset and counter-wrap sequences, then a randomized legality sweep.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  localparam int CNT_W = 4;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       ir = 8'h00;
  logic             mem_wait = 1'b0;
  ctrl_t            ctrl_o;
  state_t           state_o;
  logic             instr_done_o;
  logic [CNT_W-1:0] retired_o;

  int n_tests = 0;
  int n_fail  = 0;

  control_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ir           (ir),
    .mem_wait     (mem_wait),
    .ctrl_o       (ctrl_o),
    .state_o      (state_o),
    .instr_done_o (instr_done_o),
    .retired_o    (retired_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ir;
    logic [2:0] len;
    logic       alui;
    state_t     s0, s1, s2, s3, s4;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: change inputs on the falling edge, sample just after.
  task automatic step(input logic [7:0] ir_v, input logic w);
    @(negedge clk);
    ir = ir_v;
    mem_wait = w;
    #1;
  endtask

  function automatic state_t pick(input vec_t v, input int c);
    case (c)
      0: return v.s0;
      1: return v.s1;
      2: return v.s2;
      3: return v.s3;
      default: return v.s4;
    endcase
  endfunction

  function automatic logic [31:0] exp_ret(input int n);
    return PERF ? 32'(n % (1 << CNT_W)) : 32'd0;
  endfunction

  // Control word each state must present, with stall gating in memory states.
  function automatic ctrl_t exp_ctrl(input state_t s, input logic alui, input logic w);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH1: begin
        c.sel_mem_src_pc = 1'b1;
        if (!w) begin c.ld_ir = 1'b1; c.ld_di = 1'b1; c.ld_pc = 1'b1; end
      end
      FETCH2: begin
        c.sel_mem_src_pc = 1'b1;
        if (!w) begin c.ld_tr = 1'b1; c.ld_pc = 1'b1; end
      end
      MEM_RD: begin c.sel_mem_src_tr = 1'b1; c.ld_tr = !w; end
      LD_WB: begin
        c.sel_rf_write_src_tr_12_5 = 1'b1; c.sel_ir_4_3 = 1'b1; c.write_reg_en = 1'b1;
      end
      ST: begin c.sel_mem_src_tr = 1'b1; c.sel_ir_4_3 = 1'b1; c.mem_write = !w; end
      JMP: begin c.jump_phase = 1'b1; c.ld_pc = 1'b1; end
      ALU_EX: begin
        c.ld_alu = 1'b1; c.ld_czn = 1'b1; c.sel_czn_src_alu = 1'b1; c.sel_ir_3_2 = 1'b1;
        if (alui) c.sel_alu_src_tr = 1'b1;
        else      c.sel_alu_src_reg1 = 1'b1;
      end
      ALU_WB: begin c.sel_rf_write_src_alu = 1'b1; c.sel_ir_3_2 = 1'b1; c.write_reg_en = 1'b1; end
      MOV: begin c.sel_rf_write_src_reg1 = 1'b1; c.sel_ir_3_2 = 1'b1; c.write_reg_en = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic exp_done(input state_t s, input logic w);
    return (s == LD_WB) || (s == JMP) || (s == ALU_WB) || (s == MOV) || ((s == ST) && !w);
  endfunction

  function automatic state_t model_next(input state_t s, input logic [7:0] cur_ir,
                                        input logic [7:0] dec_ir, input logic w);
    case (s)
      FETCH1: return w ? FETCH1 : DECODE;
      DECODE: begin
        if (cur_ir[7])               return ALU_EX;
        if (cur_ir[7:4] == 4'b0110)  return MOV;
        return FETCH2;
      end
      FETCH2: begin
        if (w) return FETCH2;
        case (dec_ir[7:5])
          3'b000:  return MEM_RD;
          3'b001:  return ST;
          3'b010:  return JMP;
          default: return ALU_EX;
        endcase
      end
      MEM_RD: return w ? MEM_RD : LD_WB;
      ST:     return w ? ST : FETCH1;
      ALU_EX: return ALU_WB;
      default: return FETCH1;
    endcase
  endfunction

  initial begin
    int     n_ret;
    int     ncyc;
    int     bad;
    logic [7:0] dec_ir;
    logic [7:0] cur_ir;
    logic   cur_w;
    state_t cur_s;
    state_t nxt_s;

    vecs[0] = '{8'h05, 3'd5, 1'b0, FETCH1, DECODE, FETCH2, MEM_RD, LD_WB};
    vecs[1] = '{8'h25, 3'd4, 1'b0, FETCH1, DECODE, FETCH2, ST,     FETCH1};
    vecs[2] = '{8'h40, 3'd4, 1'b0, FETCH1, DECODE, FETCH2, JMP,    FETCH1};
    vecs[3] = '{8'h7A, 3'd5, 1'b1, FETCH1, DECODE, FETCH2, ALU_EX, ALU_WB};
    vecs[4] = '{8'h9D, 3'd4, 1'b0, FETCH1, DECODE, ALU_EX, ALU_WB, FETCH1};
    vecs[5] = '{8'hF3, 3'd4, 1'b0, FETCH1, DECODE, ALU_EX, ALU_WB, FETCH1};
    vecs[6] = '{8'h64, 3'd3, 1'b0, FETCH1, DECODE, MOV,    FETCH1, FETCH1};
    vecs[7] = '{8'h6F, 3'd3, 1'b0, FETCH1, DECODE, MOV,    FETCH1, FETCH1};
    n_ret = 0;

    // Power-on reset
    #1 rst = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'(FETCH1));
    check("rst_ctrl", 32'(ctrl_o), 32'd0);
    check("rst_done", 32'(instr_done_o), 32'd0);
    check("rst_retired", 32'(retired_o), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Table: every instruction type, no stalls
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < int'(vecs[i].len); c++) begin
        step(vecs[i].ir, 1'b0);
        check($sformatf("v%0d_c%0d_state", i, c), 32'(state_o), 32'(pick(vecs[i], c)));
        check($sformatf("v%0d_c%0d_ctrl", i, c), 32'(ctrl_o),
              32'(exp_ctrl(pick(vecs[i], c), vecs[i].alui, 1'b0)));
        check($sformatf("v%0d_c%0d_done", i, c), 32'(instr_done_o),
              32'(c == int'(vecs[i].len) - 1));
      end
      n_ret++;
    end

    // LDA with three stall cycles in MEM_RD: 8 cycles total
    ncyc = 0;
    step(8'h05, 1'b0); ncyc++;
    check("lda_retired_in", 32'(retired_o), exp_ret(n_ret));
    step(8'h05, 1'b0); ncyc++;
    step(8'h05, 1'b0); ncyc++;
    for (int k = 0; k < 3; k++) begin
      step(8'h05, 1'b1); ncyc++;
      check($sformatf("lda_wait%0d_state", k), 32'(state_o), 32'(MEM_RD));
      check($sformatf("lda_wait%0d_ld_tr", k), 32'(ctrl_o.ld_tr), 32'd0);
      check($sformatf("lda_wait%0d_addr", k), 32'(ctrl_o.sel_mem_src_tr), 32'd1);
    end
    step(8'h05, 1'b0); ncyc++;
    check("lda_rel_state", 32'(state_o), 32'(MEM_RD));
    check("lda_rel_ld_tr", 32'(ctrl_o.ld_tr), 32'd1);
    step(8'h05, 1'b0); ncyc++;
    check("lda_wb_state", 32'(state_o), 32'(LD_WB));
    check("lda_wb_done", 32'(instr_done_o), 32'd1);
    check("lda_cycles", 32'(ncyc), 32'd8);
    n_ret++;

    // JMP preceded by a stalled FETCH1: no jump_phase or loads while waiting
    for (int k = 0; k < 2; k++) begin
      step(8'h40, 1'b1);
      check($sformatf("jmp_f1wait%0d_state", k), 32'(state_o), 32'(FETCH1));
      check($sformatf("jmp_f1wait%0d_ctrl", k), 32'(ctrl_o), 32'(exp_ctrl(FETCH1, 1'b0, 1'b1)));
    end
    check("jmp_retired_in", 32'(retired_o), exp_ret(n_ret));
    for (int c = 0; c < 4; c++) begin
      step(8'h40, 1'b0);
      check($sformatf("jmp_c%0d_phase", c), 32'(ctrl_o.jump_phase), 32'(c == 3));
    end
    check("jmp_done", 32'(instr_done_o), 32'd1);
    n_ret++;

    // STA with two stall cycles in ST: no write and no retirement while held
    step(8'h25, 1'b0);
    check("sta_retired_in", 32'(retired_o), exp_ret(n_ret));
    step(8'h25, 1'b0);
    step(8'h25, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(8'h25, 1'b1);
      check($sformatf("sta_wait%0d_state", k), 32'(state_o), 32'(ST));
      check($sformatf("sta_wait%0d_wr", k), 32'(ctrl_o.mem_write), 32'd0);
      check($sformatf("sta_wait%0d_done", k), 32'(instr_done_o), 32'd0);
    end
    step(8'h25, 1'b0);
    check("sta_rel_wr", 32'(ctrl_o.mem_write), 32'd1);
    check("sta_rel_done", 32'(instr_done_o), 32'd1);
    n_ret++;

    // Reset during ALU_EX of an ALUI instruction
    step(8'h70, 1'b0);
    check("alui_retired_in", 32'(retired_o), exp_ret(n_ret));
    step(8'h70, 1'b0);
    step(8'h70, 1'b0);
    step(8'h70, 1'b0);
    check("alui_ex_state", 32'(state_o), 32'(ALU_EX));
    rst = 1'b0;
    #1;
    check("midrst_ctrl", 32'(ctrl_o), 32'd0);
    check("midrst_state", 32'(state_o), 32'(FETCH1));
    check("midrst_done", 32'(instr_done_o), 32'd0);
    check("midrst_retired", 32'(retired_o), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("midrst_hold_ctrl", 32'(ctrl_o), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    n_ret = 0;

    // 17 MOVs after reset: counter wraps to 1 with CNT_W=4
    for (int m = 0; m < 17; m++) begin
      step(8'h64, 1'b0);
      if (m == 0) begin
        check("post_rst_state", 32'(state_o), 32'(FETCH1));
        check("post_rst_retired", 32'(retired_o), 32'd0);
      end
      step(8'h64, 1'b0);
      step(8'h64, 1'b0);
      n_ret++;
    end
    step(8'h64, 1'b0);
    check("mov17_retired", 32'(retired_o), exp_ret(n_ret));
    check("mov17_state", 32'(state_o), 32'(FETCH1));

    // Random sweep: next state, control word and exclusivity every cycle
    bad = 0;
    dec_ir = 8'h64;
    for (int k = 0; k < 10000; k++) begin
      cur_s = state_o;
      cur_ir = ir;
      cur_w = mem_wait;
      if (cur_s == DECODE) dec_ir = cur_ir;
      nxt_s = model_next(cur_s, cur_ir, dec_ir, cur_w);
      step(8'($urandom), $urandom_range(0, 3) == 0);
      if (state_o !== nxt_s) bad++;
      if (ctrl_o !== exp_ctrl(state_o, dec_ir[7:4] == 4'b0111, mem_wait)) bad++;
      if (instr_done_o !== exp_done(state_o, mem_wait)) bad++;
      if (ctrl_o.sel_mem_src_pc && ctrl_o.sel_mem_src_tr) bad++;
      if (ctrl_o.sel_alu_src_tr && ctrl_o.sel_alu_src_reg1) bad++;
      if (ctrl_o.sel_ir_4_3 && ctrl_o.sel_ir_3_2) bad++;
      if (ctrl_o.ld_pc && ctrl_o.write_reg_en) bad++;
      if (ctrl_o.jump_phase && state_o != JMP) bad++;
    end
    check("random_violations", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ir  input  8  current IR contents: class in [7:5], ALU op in [7:4], dst in [3:2], src in [1:0].
REQ-005 mem_wait  input  1  memory not ready; the current memory state is held.
REQ-006 ctrl_o  output  ctrl_t  datapath control word (all load/select/enable strobes).
REQ-007 state_o  output  state_t  current FSM state, for debug.
REQ-008 instr_done_o  output  1  one-cycle pulse in the last state of every instruction.
REQ-009 retired_o  output  CNT_W  count of completed instructions.

Function
REQ-010 The block SHALL be a Moore FSM; ctrl_o, state_o and instr_done_o SHALL be functions of the state only, and mem_wait SHALL gate them as in REQ-014.
REQ-011 States: FETCH1, DECODE, FETCH2, MEM_RD, LD_WB, ST, JMP, ALU_EX, ALU_WB, MOV.
REQ-012 Decode from DECODE: ir[7:5]=000 LDA, 001 STA, 010 JMP and ir[7:4]=0111 ALUI go to FETCH2; ir[7:4]=0110 goes to MOV; ir[7]=1 goes to ALU_EX; every encoding SHALL be decoded.
REQ-013 From FETCH2: LDA goes to MEM_RD then LD_WB; STA goes to ST; JMP goes to JMP; ALUI goes to ALU_EX. ALU_EX always goes to ALU_WB. LD_WB, ST, JMP, ALU_WB and MOV go to FETCH1.
REQ-014 Memory states are FETCH1, FETCH2, MEM_RD and ST. While mem_wait=1 in one of them, the FSM SHALL stay there with every ld_*, mem_write and write_reg_en deasserted and the address select held.
REQ-015 FETCH1 outputs: sel_MEM_src_PC, ld_IR, ld_DI, ld_PC. FETCH2 outputs: sel_MEM_src_PC, ld_TR, ld_PC.
REQ-016 MEM_RD outputs: sel_MEM_src_TR, ld_TR. LD_WB outputs: sel_RF_write_src_TR_12_5, sel_IR_4_3, write_reg_en.
REQ-017 ST outputs: sel_MEM_src_TR, sel_IR_4_3, mem_write.
REQ-018 JMP outputs: jump_phase and ld_PC; the PC source is chosen by the datapath condition ANDed with jump_phase, and jump_phase SHALL be 0 in every other state.
REQ-019 ALU_EX outputs: ld_ALU, ld_CZN, sel_CZN_src_ALU, sel_IR_3_2, plus sel_ALU_src_TR for ALUI or sel_ALU_src_reg1 otherwise.
REQ-020 ALU_WB outputs: sel_RF_write_src_ALU, sel_IR_3_2, write_reg_en. MOV outputs: sel_RF_write_src_reg1, sel_IR_3_2, write_reg_en.
REQ-021 Latency with no wait: MOV 3 cycles; STA, JMP and ALU reg-reg 4 cycles; LDA and ALUI 5 cycles.
REQ-022 Mutually exclusive select pairs SHALL never be asserted together, and ld_PC SHALL never coincide with write_reg_en.
REQ-023 retired_o SHALL increment by 1 in each cycle that instr_done_o=1 and SHALL wrap from all-ones to 0.

Reset
REQ-024 rst=0 SHALL force state FETCH1, retired_o=0 and instr_done_o=0 immediately.
REQ-025 While rst=0, ctrl_o SHALL be all-zero.
REQ-026 Reset asserted mid-instruction SHALL abandon the instruction without a retirement count; the first rising edge after release SHALL perform FETCH1.

Configuration
REQ-027 With CTRL_PERF_CNT_EN defined, the retired counter SHALL be instantiated as specified; without it, retired_o SHALL be tied to 0 and no counter flops exist.

Structure
REQ-028 Package cpu_ctrl_pkg SHALL hold ctrl_t (packed struct, one bit per strobe), state_t (enum), and class/opcode constants; the datapath SHALL import the same ctrl_t.
REQ-029 One sub-module, instr_counter, SHALL hold the retired counter and be instantiated only under CTRL_PERF_CNT_EN.

Verification
REQ-030 Scenario: ir=0x9D (ALU reg-reg) -> states FETCH1, DECODE, ALU_EX, ALU_WB; write_reg_en only in cycle 4; instr_done_o pulses in cycle 4.
REQ-031 Scenario: ir=0x05 (LDA) with mem_wait=1 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with ld_TR low while waiting; total 8 cycles.
REQ-032 Scenario: ir=0x40 (JMP) -> jump_phase=1 only in the 4th cycle; jump_phase is never 1 during FETCH1.
REQ-033 Scenario: rst pulled low during ALU_EX of ir=0x70 -> ctrl_o=0 at once; after release, FETCH1 and retired_o unchanged at 0.
REQ-034 Scenario: with CTRL_PERF_CNT_EN and CNT_W=4, 17 MOV instructions (ir=0x64) -> retired_o=1; without the macro, retired_o=0 throughout.
REQ-035 Scenario: random ir values over 10k cycles -> assertions on REQ-022 and a legal next state hold in every cycle.
